// File: rtl/stdp_layer.sv
// Single-layer spiking unit: N_PRE plastic synapses feed one leaky
// integrate-and-fire neuron with pair-based STDP and a refractory FSM.
module stdp_layer #(
  parameter int N_PRE        = 4,
  parameter int WIDTH        = 8,
  parameter int DECIMAL_BITS = 4,
  parameter int LEAK_SHIFT   = 2,
  parameter int REFRACT      = 2,
  parameter int W_INIT       = 16,
  parameter int W_MIN        = 4,
  parameter int W_MAX        = 127,
  parameter int A_PLUS       = 2,
  parameter int A_MINUS      = 1,
  parameter int TRACE_INC    = 16,
  parameter int TRACE_SHIFT  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PRE-1:0]           pre_spike,
  input  logic signed [WIDTH-1:0]    i_stim,
  input  logic                       learn_en,
  input  logic [$clog2(N_PRE)-1:0]   w_sel,
  output logic [WIDTH-1:0]           w_out,
  output logic                       post_spike,
  output logic signed [WIDTH-1:0]    v_mem,
  output logic                       refractory
);

  localparam int SW    = WIDTH + $clog2(N_PRE) + 2;
  localparam int SEL_W = $clog2(N_PRE);
  localparam int CNT_W = $clog2(REFRACT + 2);
  localparam int ONE   = 1 << DECIMAL_BITS;

  localparam logic signed [WIDTH-1:0] V_REST   = WIDTH'(-4 * ONE);
  localparam logic signed [WIDTH-1:0] V_THRESH = WIDTH'(2 * ONE);
  localparam logic signed [WIDTH+1:0] W_LO     = (WIDTH + 2)'(W_MIN);
  localparam logic signed [WIDTH+1:0] W_HI     = (WIDTH + 2)'(W_MAX);
  localparam logic signed [WIDTH+1:0] DW_PLUS  = (WIDTH + 2)'(A_PLUS);
  localparam logic signed [WIDTH+1:0] DW_MINUS = (WIDTH + 2)'(A_MINUS);

  typedef enum logic {ST_INTEGRATE, ST_REFRACT} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic signed [WIDTH-1:0] v_mem_n;
  logic                    post_spike_n;
  logic [WIDTH-1:0]        weight    [N_PRE];
  logic [WIDTH-1:0]        weight_n  [N_PRE];
  logic [WIDTH-1:0]        pre_trace [N_PRE];
  logic [WIDTH-1:0]        post_trace;
  logic signed [SW-1:0]    syn_sum, tot, v_wide;
  logic signed [WIDTH-1:0] v_next;

  function automatic logic signed [SW-1:0] sext(input logic signed [WIDTH-1:0] x);
    return {{(SW - WIDTH){x[WIDTH-1]}}, x};
  endfunction

  // Saturating bump on a spike, otherwise decay that always removes at least 1.
  function automatic logic [WIDTH-1:0] trace_step(input logic [WIDTH-1:0] tr,
                                                  input logic spike);
    logic [WIDTH:0]   inc;
    logic [WIDTH-1:0] dec;
    inc = {1'b0, tr} + (WIDTH + 1)'(TRACE_INC);
    dec = tr >> TRACE_SHIFT;
    if (dec == '0) dec = WIDTH'(1);
    if (spike)          return inc[WIDTH] ? '1 : inc[WIDTH-1:0];
    else if (tr != '0)  return tr - dec;
    else                return tr;
  endfunction

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < N_PRE; i++)
      if (pre_spike[i]) syn_sum = syn_sum + $signed({{(SW - WIDTH){1'b0}}, weight[i]});
    tot    = sext(i_stim) + syn_sum + (sext(V_REST) - sext(v_mem));
    v_wide = sext(v_mem) + (tot >>> LEAK_SHIFT);
    if (v_wide[SW-1:WIDTH-1] == '0 || v_wide[SW-1:WIDTH-1] == '1)
      v_next = v_wide[WIDTH-1:0];
    else
      v_next = v_wide[SW-1] ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    v_mem_n      = v_mem;
    post_spike_n = 1'b0;
    case (state)
      ST_INTEGRATE: begin
        if (v_next >= V_THRESH) begin
          v_mem_n      = V_REST;
          post_spike_n = 1'b1;
          if (REFRACT > 0) begin
            cnt_n   = CNT_W'(REFRACT);
            state_n = ST_REFRACT;
          end
        end else begin
          v_mem_n = v_next;
        end
      end
      ST_REFRACT: begin
        v_mem_n = V_REST;
        cnt_n   = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = ST_INTEGRATE;
      end
    endcase
  end

  // LTP and LTD are judged on pre-edge traces and summed before clamping.
  always_comb begin
    for (int i = 0; i < N_PRE; i++) begin
      logic signed [WIDTH+1:0] w_calc;
      w_calc = $signed({2'b00, weight[i]});
      if (post_spike && pre_trace[i] != '0)  w_calc = w_calc + DW_PLUS;
      if (pre_spike[i] && post_trace != '0)  w_calc = w_calc - DW_MINUS;
      if (w_calc > W_HI)       w_calc = W_HI;
      else if (w_calc < W_LO)  w_calc = W_LO;
      weight_n[i] = learn_en ? w_calc[WIDTH-1:0] : weight[i];
    end
  end

  always_comb begin
    w_out = '0;
    for (int i = 0; i < N_PRE; i++)
      if (w_sel == SEL_W'(i)) w_out = weight[i];
  end

  // NOTE: weights and traces live in flops, not a RAM, and all of them are
  // reset so that a reset genuinely forgets everything learned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INTEGRATE;
      cnt        <= '0;
      v_mem      <= V_REST;
      post_spike <= 1'b0;
      post_trace <= '0;
      for (int i = 0; i < N_PRE; i++) begin
        pre_trace[i] <= '0;
        weight[i]    <= WIDTH'(W_INIT);
      end
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      v_mem      <= v_mem_n;
      post_spike <= post_spike_n;
      post_trace <= trace_step(post_trace, post_spike);
      for (int i = 0; i < N_PRE; i++) begin
        pre_trace[i] <= trace_step(pre_trace[i], pre_spike[i]);
        weight[i]    <= weight_n[i];
      end
    end
  end

  assign refractory = (state == ST_REFRACT);

endmodule

// File: tb/tb_stdp_layer.sv
// Directed bench for stdp_layer: integration, spiking, refractory timing,
// STDP weight updates, clamps, trace decay and asynchronous reset.
module tb_stdp_layer;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        pre_spike;
  logic signed [7:0] i_stim;
  logic              learn_en;
  logic [1:0]        w_sel;
  logic [7:0]        w_out;
  logic              post_spike;
  logic signed [7:0] v_mem;
  logic              refractory;

  logic [1:0]        aux_sel;
  logic [7:0]        aux_w_out;
  logic              aux_post;
  logic signed [7:0] aux_v;
  logic              aux_refr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stdp_layer dut (
    .clk        (clk),
    .reset      (reset),
    .pre_spike  (pre_spike),
    .i_stim     (i_stim),
    .learn_en   (learn_en),
    .w_sel      (w_sel),
    .w_out      (w_out),
    .post_spike (post_spike),
    .v_mem      (v_mem),
    .refractory (refractory)
  );

  // Three-channel instance so that an out-of-range w_sel is reachable.
  stdp_layer #(.N_PRE(3)) aux_dut (
    .clk        (clk),
    .reset      (reset),
    .pre_spike  (3'b000),
    .i_stim     (8'sd0),
    .learn_en   (1'b0),
    .w_sel      (aux_sel),
    .w_out      (aux_w_out),
    .post_spike (aux_post),
    .v_mem      (aux_v),
    .refractory (aux_refr)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input logic signed [7:0] stim, input logic learn);
    reset     = 1'b1;
    pre_spike = '0;
    i_stim    = stim;
    learn_en  = learn;
    w_sel     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_weights(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
    int exp_w[4];
    exp_w = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      w_sel = 2'(i);
      #1;
      check(tag, 32'(w_out), exp_w[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         exp_v2[3];
    int         exp_v3[4];
    int         exp_tr[10];
    int         nspk;
    int         npairs;
    logic [7:0] wmax, wmin, late_min, late_max;

    exp_v2 = '{-48, -36, -27};
    exp_v3 = '{-33, -9, 9, 22};
    exp_tr = '{12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
    pre_spike = '0; i_stim = '0; learn_en = 1'b0; w_sel = '0; aux_sel = '0;

    // Reset values, then idle.
    repeat (2) @(negedge clk);
    check("rst_v", 32'(v_mem), -64);
    check("rst_post", 32'(post_spike), 0);
    check("rst_refr", 32'(refractory), 0);
    check("rst_w", 32'(w_out), 16);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_v", 32'(v_mem), -64);
    end
    check_weights("idle_w", 16, 16, 16, 16);
    aux_sel = 2'd2; #1;
    check("aux_w_in_range", 32'(aux_w_out), 16);
    aux_sel = 2'd3; #1;
    check("aux_w_out_of_range", 32'(aux_w_out), 0);
    check("aux_idle", 32'({aux_post, aux_refr, aux_v}), 32'({2'b00, -8'sd64}));

    // Sub-threshold drive converges to -3 without spiking.
    apply_reset(8'sd64, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sub_v", 32'(v_mem), exp_v2[i]);
    end
    nspk = 0;
    repeat (40) begin
      @(negedge clk);
      if (post_spike) nspk++;
    end
    check("sub_no_spike", nspk, 0);
    check("sub_converged", 32'(v_mem), -3);

    // Supra-threshold drive: spike on edge 5, two refractory cycles.
    apply_reset(8'sd127, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sup_v", 32'(v_mem), exp_v3[i]);
      check("sup_post_lo", 32'(post_spike), 0);
    end
    @(negedge clk);
    check("spk_post", 32'(post_spike), 1);
    check("spk_v", 32'(v_mem), -64);
    check("spk_refr", 32'(refractory), 1);
    @(negedge clk);
    check("ref1_post", 32'(post_spike), 0);
    check("ref1_refr", 32'(refractory), 1);
    check("ref1_v", 32'(v_mem), -64);
    @(negedge clk);
    check("ref2_refr", 32'(refractory), 0);
    check("ref2_v", 32'(v_mem), -64);
    @(negedge clk);
    check("resume_v", 32'(v_mem), -33);

    // LTP on channel 1, then LTD on channel 2.
    apply_reset(8'sd127, 1'b1);
    repeat (2) @(negedge clk);
    pre_spike = 4'b0010;
    @(negedge clk);
    pre_spike = 4'b0000;
    check("learn_v3", 32'(v_mem), 13);
    @(negedge clk);
    check("learn_v4", 32'(v_mem), 25);
    @(negedge clk);
    check("learn_post", 32'(post_spike), 1);
    check_weights("learn_pre_ltp", 16, 16, 16, 16);
    @(negedge clk);
    pre_spike = 4'b0100;
    check_weights("learn_ltp", 16, 18, 16, 16);
    @(negedge clk);
    pre_spike = 4'b0000;
    learn_en  = 1'b0;
    check_weights("learn_ltd", 16, 18, 15, 16);

    // Repeated pre/post pairing on channel 0 saturates at W_MAX.
    apply_reset(8'sd127, 1'b1);
    wmax = '0; npairs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (w_out > wmax) wmax = w_out;
      if (post_spike) npairs++;
      pre_spike = {3'b000, post_spike};
    end
    pre_spike = '0;
    learn_en  = 1'b0;
    check("ltp_pairs_enough", 32'(npairs >= 60), 1);
    check("ltp_max_seen", 32'(wmax), 127);
    check_weights("ltp_sat", 127, 16, 16, 16);

    // Continuous presynaptic firing drives channel 0 to the W_MIN floor.
    apply_reset(8'sd127, 1'b1);
    pre_spike = 4'b0001;
    wmin = 8'hff; late_min = 8'hff; late_max = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (w_out < wmin) wmin = w_out;
      if (c >= 200) begin
        if (w_out < late_min) late_min = w_out;
        if (w_out > late_max) late_max = w_out;
      end
    end
    check("ltd_floor", 32'(wmin), 4);
    check("ltd_late_min", 32'(late_min), 4);
    check("ltd_late_max_le5", 32'(late_max <= 8'd5), 1);

    // Same stimuli with learning disabled: weights frozen, traces still move.
    apply_reset(8'sd127, 1'b0);
    repeat (200) begin
      @(negedge clk);
      pre_spike = {3'b000, post_spike};
    end
    pre_spike = 4'b0001;
    repeat (100) @(negedge clk);
    check("frozen_trace_sat", 32'(dut.pre_trace[0]), 255);
    pre_spike = '0;
    check_weights("frozen_w", 16, 16, 16, 16);

    // Single pre_spike[3] trace decay.
    apply_reset(8'sd0, 1'b0);
    pre_spike = 4'b1000;
    @(negedge clk);
    pre_spike = 4'b0000;
    check("trace_peak", 32'(dut.pre_trace[3]), 16);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("trace_decay", 32'(dut.pre_trace[3]), exp_tr[i]);
    end

    // Asynchronous reset in the middle of a decay.
    pre_spike = 4'b1000;
    @(negedge clk);
    pre_spike = 4'b0000;
    repeat (2) @(negedge clk);
    check("mid_decay_trace", 32'(dut.pre_trace[3]), 9);
    #1 reset = 1'b1;
    #1;
    check("async_trace", 32'(dut.pre_trace[3]), 0);
    check("async_decay_v", 32'(v_mem), -64);
    check("async_decay_flags", 32'({post_spike, refractory}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset in the middle of refractory, after a weight change.
    apply_reset(8'sd127, 1'b1);
    repeat (2) @(negedge clk);
    pre_spike = 4'b0010;
    @(negedge clk);
    pre_spike = 4'b0000;
    repeat (3) @(negedge clk);
    check("mid_ref_refr", 32'(refractory), 1);
    w_sel = 2'd1;
    #1;
    check("mid_ref_w", 32'(w_out), 18);
    #1 reset = 1'b1;
    #1;
    check("async_ref_refr", 32'(refractory), 0);
    check("async_ref_v", 32'(v_mem), -64);
    check("async_ref_post", 32'(post_spike), 0);
    check("async_ref_w", 32'(w_out), 16);
    check("async_ref_ptrace", 32'(dut.post_trace), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_integrates", 32'(v_mem), -33);
    check("after_reset_refr", 32'(refractory), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
